// File: rtl/text_overlay_ctrl.sv
// Character-cell text overlay: owns the COLS x ROWS character RAM, shares its single
// port between display fetches (priority), host writes and a clear sequence, and
// drives the external font lookup to produce a per-pixel overlay flag at 2-cycle latency.
module text_overlay_ctrl #(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 30,
    parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       pix_valid,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [6:0] wr_col,
    input  logic [4:0] wr_row,
    input  logic [7:0] wr_char,
    input  logic       clear_req,
    output logic       busy,
    output logic [7:0] font_code,
    output logic [2:0] font_x,
    output logic [3:0] font_y,
    input  logic       font_pixel,
    output logic       ovl_valid,
    output logic       ovl_on
);
    localparam int              DEPTH  = COLS * ROWS;
    localparam int              AW     = $clog2(DEPTH);
    localparam int              STAGES = 2;
    localparam logic [6:0]      COLS_L = 7'(COLS);
    localparam logic [5:0]      ROWS_L = 6'(ROWS);
    localparam logic [AW-1:0]   LAST   = AW'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] clr_addr, clr_addr_nx;

    logic [7:0]    mem [DEPTH];
    logic [7:0]    ram_q;
    logic          in_area, fetch, free;
    logic [AW-1:0] fetch_addr, wr_addr, port_addr, ram_waddr;
    logic [7:0]    ram_wdata;
    logic          ram_we, wr_in_range, accept;

    assign in_area     = (pix_y[9:4] < ROWS_L) && (pix_x[9:3] < COLS_L);
    assign fetch       = pix_valid && (pix_x[2:0] == 3'd0) && in_area;
    assign free        = !fetch;
    assign fetch_addr  = AW'(pix_y[9:4]) * AW'(COLS) + AW'(pix_x[9:3]);
    assign wr_addr     = AW'(wr_row) * AW'(COLS) + AW'(wr_col);
    assign wr_in_range = (wr_col < COLS_L) && ({1'b0, wr_row} < ROWS_L);
    assign busy        = (state == CLEAR);

    // Writes only ever happen on free cycles, so one address mux models the single port.
    always_comb begin
        state_nx    = state;
        clr_addr_nx = clr_addr;
        accept      = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = clr_addr;
        ram_wdata   = CLEAR_CHAR;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nx    = CLEAR;
                    clr_addr_nx = '0;
                end else begin
                    accept = free && !reset;
                    if (wr_valid && accept && wr_in_range) begin
                        ram_we    = 1'b1;
                        ram_waddr = wr_addr;
                        ram_wdata = wr_char;
                    end
                end
            end
            CLEAR: begin
                if (free) begin
                    ram_we = 1'b1;
                    if (clr_addr == LAST) state_nx = IDLE;
                    else                  clr_addr_nx = clr_addr + AW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign wr_ready  = accept;
    assign port_addr = fetch ? fetch_addr : ram_waddr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            clr_addr <= '0;
        end else begin
            state    <= state_nx;
            clr_addr <= clr_addr_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[port_addr] <= ram_wdata;
    end

    // Pixel pipeline: stage 1 holds RAM data / glyph coords, stage 2 samples the font bit.
    logic [2:0]        x_s1;
    logic [3:0]        y_s1;
    logic              area_s1, fetch_s1;
    logic [7:0]        cell_char;
    logic [STAGES:1]   vld_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_q     <= '0;
            x_s1      <= '0;
            y_s1      <= '0;
            area_s1   <= 1'b0;
            fetch_s1  <= 1'b0;
            cell_char <= '0;
            vld_pipe  <= '0;
            ovl_on    <= 1'b0;
        end else begin
            if (fetch) ram_q <= mem[port_addr];
            x_s1      <= pix_x[2:0];
            y_s1      <= pix_y[3:0];
            area_s1   <= in_area;
            fetch_s1  <= fetch;
            if (fetch_s1) cell_char <= ram_q;
            vld_pipe  <= {vld_pipe[STAGES-1:1], pix_valid};
            ovl_on    <= font_pixel && area_s1 && vld_pipe[1];
        end
    end

    assign font_code = fetch_s1 ? ram_q : cell_char;
    assign font_x    = x_s1;
    assign font_y    = y_s1;
    assign ovl_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Self-checking bench for text_overlay_ctrl: reference model of the character RAM,
// clear sequencer and pixel pipeline, with a 2-deep scoreboard for the overlay outputs.
module tb_text_overlay_ctrl;
    localparam int         COLS  = 80;
    localparam int         ROWS  = 30;
    localparam int         DEPTH = COLS * ROWS;
    localparam logic [7:0] CLR   = 8'h20;

    logic       clk, reset;
    logic [9:0] pix_x, pix_y;
    logic       pix_valid, wr_valid, wr_ready, clear_req, busy;
    logic [6:0] wr_col;
    logic [4:0] wr_row;
    logic [7:0] wr_char, font_code;
    logic [2:0] font_x;
    logic [3:0] font_y;
    logic       font_pixel, ovl_valid, ovl_on;

    text_overlay_ctrl #(.COLS(COLS), .ROWS(ROWS), .CLEAR_CHAR(CLR)) dut (
        .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col), .wr_row(wr_row),
        .wr_char(wr_char), .clear_req(clear_req), .busy(busy), .font_code(font_code),
        .font_x(font_x), .font_y(font_y), .font_pixel(font_pixel),
        .ovl_valid(ovl_valid), .ovl_on(ovl_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Font memory stand-in: an arbitrary but fixed glyph pattern per code.
    function automatic logic fbit(logic [7:0] c, logic [2:0] x, logic [3:0] y);
        return c[x] ^ y[0] ^ (x == y[2:0]);
    endfunction
    assign font_pixel = fbit(font_code, font_x, font_y);

    typedef struct packed {
        logic       pv;
        logic [9:0] px, py;
        logic       wv;
        logic [6:0] wc;
        logic [4:0] wr;
        logic [7:0] wch;
        logic       clr, rst;
    } stim_t;

    typedef struct {
        logic       pv;
        int         x, y;
        logic [1:0] exp;
    } tv_t;

    int         n_vec = 0, n_err = 0;
    logic [7:0] mdl [DEPTH];
    logic [7:0] m_cell;
    logic [2:0] m_x;
    logic [3:0] m_y;
    logic       m_clear;
    int         m_caddr;
    logic [1:0] q[$];
    logic       last_acc, last_free, last_busy, last_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic stim_t pix(logic pv, int x, int y);
        stim_t s = '0;
        s.pv = pv;
        s.px = 10'(x);
        s.py = 10'(y);
        return s;
    endfunction

    task automatic step(input stim_t s, input logic use_tbl = 1'b0, input logic [1:0] tbl = 2'b00);
        logic area, fetch, rdy, bsy;
        logic [1:0] e;
        pix_valid = s.pv; pix_x = s.px; pix_y = s.py;
        wr_valid = s.wv; wr_col = s.wc; wr_row = s.wr; wr_char = s.wch;
        clear_req = s.clr; reset = s.rst;
        #1;
        area  = (int'(s.py[9:4]) < ROWS) && (int'(s.px[9:3]) < COLS);
        fetch = s.pv && (s.px[2:0] == 3'd0) && area;
        rdy   = !s.rst && !fetch && !m_clear && !s.clr;
        bsy   = m_clear && !s.rst;
        last_rdy  = wr_ready;
        last_busy = busy;
        chk("ready_busy", 32'({wr_ready, busy}), 32'({rdy, bsy}));
        last_acc  = s.wv && rdy;
        last_free = !fetch;
        if (s.rst) begin
            m_clear = 1'b0; m_cell = '0; m_x = '0; m_y = '0;
            q.delete();
            q.push_back(2'b00);
            q.push_back(2'b00);
        end else begin
            if (fetch) m_cell = mdl[int'(s.py[9:4]) * COLS + int'(s.px[9:3])];
            m_x = s.px[2:0];
            m_y = s.py[3:0];
            e = {s.pv, s.pv && area && fbit(m_cell, m_x, m_y)};
            q.push_back(use_tbl ? tbl : e);
            if (m_clear) begin
                if (!fetch) begin
                    mdl[m_caddr] = CLR;
                    m_caddr++;
                    if (m_caddr == DEPTH) m_clear = 1'b0;
                end
            end else if (s.clr) begin
                m_clear = 1'b1;
                m_caddr = 0;
            end else if (last_acc && int'(s.wc) < COLS && int'(s.wr) < ROWS) begin
                mdl[int'(s.wr) * COLS + int'(s.wc)] = s.wch;
            end
        end
        @(posedge clk); #1;
        chk("font_lookup", 32'({font_code, font_x, font_y}), 32'({m_cell, m_x, m_y}));
        e = q.pop_front();
        chk("ovl", 32'({ovl_valid, ovl_on}), 32'(e));
    endtask

    task automatic run_clear_blank();
        stim_t s = pix(1'b0, 0, 0);
        s.clr = 1'b1;
        step(s);
        for (int i = 0; i < 3000 && m_clear; i++) step(pix(1'b0, 0, 0));
        chk("clear_done", 32'(busy), 32'(0));
    endtask

    task automatic scan_all(output int n5a, output int nclr);
        n5a = 0; nclr = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                step(pix(1'b1, c * 8, r * 16));
                if (font_code == 8'h5A) n5a++;
                if (font_code != CLR) nclr++;
            end
    endtask

    initial begin
        tv_t   tbl [8];
        stim_t s;
        int    wi, n5a, nclr, cnt, rx, ry;
        logic  started;

        tbl[0] = '{1'b1, 0,    480,  2'b10};
        tbl[1] = '{1'b1, 8,    480,  2'b10};
        tbl[2] = '{1'b1, 640,  0,    2'b10};
        tbl[3] = '{1'b1, 1000, 100,  2'b10};
        tbl[4] = '{1'b0, 0,    0,    2'b00};
        tbl[5] = '{1'b0, 3,    5,    2'b00};
        tbl[6] = '{1'b1, 0,    1023, 2'b10};
        tbl[7] = '{1'b0, 0,    480,  2'b00};

        m_clear = 1'b0; m_caddr = 0; m_cell = '0; m_x = '0; m_y = '0;
        s = pix(1'b0, 0, 0); s.rst = 1'b1;
        step(s); step(s);
        run_clear_blank();

        // 'A' at (0,0) then scan its full 8x16 cell
        s = pix(1'b0, 0, 0); s.wv = 1'b1; s.wch = 8'h41;
        step(s);
        chk("write_A_ack", 32'(last_rdy), 32'(1));
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 8; x++) step(pix(1'b1, x, y));

        // host writes held across an active line
        wi = 0;
        for (int x = 0; x < 640; x++) begin
            s = pix(1'b1, x, 16);
            if (wi < 16) begin
                s.wv = 1'b1; s.wc = 7'(3 * wi + 1); s.wr = 5'd5; s.wch = 8'(8'h30 + wi);
            end
            step(s);
            if (s.wv && last_rdy) wi++;
        end
        chk("line_writes", 32'(wi), 32'(16));
        for (int c = 0; c < COLS; c++) step(pix(1'b1, c * 8, 5 * 16));

        // out-of-range writes complete the handshake and are dropped
        s = pix(1'b0, 0, 0); s.wv = 1'b1; s.wch = 8'h5A;
        s.wc = 7'd80;  s.wr = 5'd0;  step(s); chk("oor_col_ack", 32'(last_rdy), 32'(1));
        s.wc = 7'd0;   s.wr = 5'd30; step(s); chk("oor_row_ack", 32'(last_rdy), 32'(1));
        s.wc = 7'd127; s.wr = 5'd31; step(s); chk("oor_both_ack", 32'(last_rdy), 32'(1));
        scan_all(n5a, nclr);
        chk("no_5A", 32'(n5a), 32'(0));

        // border / invalid pixel table
        foreach (tbl[i]) step(pix(tbl[i].pv, tbl[i].x, tbl[i].y), 1'b1, tbl[i].exp);
        step(pix(1'b0, 0, 0)); step(pix(1'b0, 0, 0));

        // clear during active video, with a second clear_req mid-sequence
        rx = 0; ry = 0; cnt = 0; started = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            s = pix(rx < 640 && ry < 480, rx, ry);
            if (i == 0 || cnt == 1000) s.clr = 1'b1;
            step(s);
            if (last_busy) started = 1'b1;
            if (last_busy && last_free) cnt++;
            if (started && !last_busy) break;
            rx++;
            if (rx == 800) begin rx = 0; ry = (ry == 524) ? 0 : ry + 1; end
        end
        chk("clear_free_cycles", 32'(cnt), 32'(DEPTH));
        scan_all(n5a, nclr);
        chk("all_cleared", 32'(nclr), 32'(0));

        // reset in the middle of a clear
        s = pix(1'b0, 0, 0); s.clr = 1'b1;
        step(s);
        for (int i = 0; i < 2000 && m_caddr < 1000; i++) step(pix(1'b0, 0, 0));
        s = pix(1'b0, 0, 0); s.rst = 1'b1;
        step(s);
        chk("busy_after_rst", 32'(last_busy), 32'(0));
        s = pix(1'b0, 0, 0); s.wv = 1'b1; s.wc = 7'd2; s.wr = 5'd2; s.wch = 8'h51;
        step(s);
        chk("ready_resume", 32'(last_rdy), 32'(1));
        run_clear_blank();
        scan_all(n5a, nclr);
        chk("reclear_all", 32'(nclr), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/text_overlay_ctrl.md
Name: text_overlay_ctrl

Overview:
- Character-cell text overlay controller for the VGA pipeline.
- Owns a single-port character RAM of COLS×ROWS ASCII codes and arbitrates it between display fetches and host writes. Display fetches always have priority.
- Sequences the 8×16 glyph lookup: drives symbol_code/x/y into the external font memory and samples its combinational glyph bit.
- Emits a per-pixel overlay-on flag aligned to a fixed 2-cycle latency, for the pixel mixer downstream of the Mandelbrot renderer.

Parameters:
- COLS, 80, text columns (cell width 8 px)
- ROWS, 30, text rows (cell height 16 px)
- CLEAR_CHAR, 8'h20, code written by the clear sequence

Ports:
- clk  input  1  pixel clock
- reset  input  1  asynchronous, active-high reset
- pix_x  input  10  current pixel column
- pix_y  input  10  current pixel row
- pix_valid  input  1  active-video qualifier for pix_x/pix_y
- wr_valid  input  1  host write request
- wr_ready  output  1  host write accepted this cycle
- wr_col  input  7  target column
- wr_row  input  5  target row
- wr_char  input  8  ASCII code to store
- clear_req  input  1  pulse: fill whole RAM with CLEAR_CHAR
- busy  output  1  clear sequence in progress
- font_code  output  8  symbol code to font memory
- font_x  output  3  glyph pixel column
- font_y  output  4  glyph pixel row
- font_pixel  input  1  glyph bit returned combinationally by font memory
- ovl_valid  output  1  pix_valid delayed 2 cycles
- ovl_on  output  1  overlay pixel lit, aligned with ovl_valid

Behaviour:
- Reset values: wr_ready=0, busy=0, font_code=0, font_x=0, font_y=0, ovl_valid=0, ovl_on=0, FSM=IDLE, all pipeline valids=0. Character RAM contents are not reset.
- Character RAM: COLS*ROWS×8, synchronous read with 1-cycle latency, addr = row*COLS+col. The multiply is a constant; no runtime divider.
- Display fetch cycle (cycle T): pix_valid && pix_x[2:0]==0 && pix_y[9:4] < ROWS && pix_x[9:3] < COLS. The RAM port reads the cell address.
- Stage 1 (T+1):
  - Register pix_x[2:0], pix_y[3:0], in_area and valid.
  - cell_char loads RAM data on fetch-follow cycles and holds for the remaining 7 pixels of the cell.
  - Drive font_code=cell_char (the just-read data when x==0), font_x, font_y.
- Stage 2 (T+2): ovl_on = font_pixel && in_area && valid; ovl_valid = valid. Latency is exactly 2 cycles for every pixel.
- Pixels outside the text area, or with pix_valid=0, give ovl_on=0.
- Arbitration: the port is free on any cycle that is not a display fetch.
  - Host write: wr_ready = free && FSM==IDLE. The write commits when wr_valid && wr_ready.
  - wr_ready may toggle while wr_valid is held; the host holds its data until accepted.
- Out-of-range writes (wr_col≥COLS or wr_row≥ROWS) complete the handshake and are discarded. The RAM is unchanged.
- FSM states:
  - IDLE: clear_req → CLEAR with addr=0, busy=1.
  - CLEAR: on each free cycle, write CLEAR_CHAR at addr and increment. After writing address COLS*ROWS-1 → IDLE with busy=0. Stalls (no write, addr held) on fetch cycles.
- clear_req while in CLEAR is ignored. clear_req and wr_valid in the same IDLE cycle: the clear wins, wr_ready=0.
- A host write to a cell in the same cycle as its display fetch cannot occur, because fetch has priority. The new char appears from the next fetch of that cell.
- Reset mid-CLEAR: immediate return to IDLE, busy=0. Partially cleared RAM is acceptable.

Test Plan:
- Write 'A' (8'h41) at col 0,row 0 during blanking, then scan pix_y=0..15, pix_x=0..7 → font_code=8'h41 at T+1 and ovl_on equals the font bits at T+2; a bench font model bit for x=0,y=0 is reproduced.
- Hold wr_valid across an active line with pix_x stepping every cycle → wr_ready=0 exactly on cycles with pix_x[2:0]==0; no write is lost; the final RAM matches.
- Write 'Z' at col 80 / row 30 → handshake completes; scanning every cell shows no 8'h5A.
- clear_req during active video → busy high; completes after 2400 free cycles; all cells read 8'h20; a second clear_req mid-sequence does not restart the count.
- Assert reset at clear address 1000 → busy=0 and wr_ready resumes next free cycle; a subsequent clear_req completes normally.
- pix_y=480 (row 30) with pix_valid=1 → ovl_valid=1, ovl_on=0; pix_valid=0 → ovl_valid=0 two cycles later.
